jtag_host_driver: RTL and testbench
===================================

# jtag_host_driver

On-FPGA JTAG initiator that drives the PULPissimo debug TAP from fabric logic, so test and boot code can be loaded without an external probe. It accepts scan commands over a valid/ready interface and produces TCK/TMS/TDI from the reference clock. It samples TDO and returns the captured bits over a second valid/ready interface. It sits beside the SoC in the board top level, with its outputs muxed onto the SoC JTAG inputs in place of the pad signals.

## Interface
- CLK_DIV, 4: ref clocks per TCK half-period, ≥2
- ref_clk_i  in  1  reference clock; all logic on rising edge
- pad_reset  in  1  asynchronous, active-high reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_type_i  in  2  0=TAP_RESET, 1=IR_SCAN, 2=DR_SCAN, 3=IDLE_CYCLES
- cmd_len_i  in  5  bit/cycle count minus one (0→1, 31→32)
- cmd_data_i  in  32  TDI bits, LSB shifted first
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_data_o  out  32  captured TDO, bit0 = first captured, unused upper bits 0
- jtag_tck_o  out  1  TCK to TAP
- jtag_tms_o  out  1  TMS to TAP
- jtag_tdi_o  out  1  TDI to TAP
- jtag_tdo_i  in  1  TDO from TAP
- busy_o  out  1  high from command accept until response handshake

## Operation
- FSM states: IDLE → HEAD → SHIFT → TAIL → RESP → IDLE. TAP_RESET and IDLE_CYCLES skip SHIFT.
- IDLE: cmd_ready_o=1; on accept, latch type, len and data, then go to HEAD.
- Command TMS sequences. Every scan starts and ends in Run-Test/Idle.
  - TAP_RESET: TMS 1,1,1,1,1,0 (6 TCK). Data ignored.
  - IR_SCAN: head TMS 1,1,0,0. SHIFT len+1 bits with TMS=0, except TMS=1 on the last bit. Tail TMS 1,0.
  - DR_SCAN: head TMS 1,0,0. SHIFT and tail as IR_SCAN.
  - IDLE_CYCLES: len+1 TCK with TMS=0, TDI=0.
- TDI=0 outside SHIFT.
- SHIFT:
  - TDI = data[0] at each falling edge; the data register shifts right.
  - TDO sampled at each rising edge into capture[bit_index].
- RESP:
  - rsp_valid_o=1 and rsp_data_o stable until rsp_ready_i.
  - rsp_data_o = 0 for TAP_RESET and IDLE_CYCLES.
- After reset the TAP state is undefined. The user must issue TAP_RESET before any scan. The block does not enforce this.

## Timing
- TCK period = 2·CLK_DIV ref clocks, 50% duty, idle low. TCK toggles only outside IDLE and RESP.
- Each TCK cycle has two phases:
  - Low phase (CLK_DIV clocks): TMS and TDI are updated on the ref clock where TCK goes 1→0, and on the first low phase.
  - High phase: TDO is registered on the ref clock where TCK goes 0→1.
- Latency from accept to rsp_valid_o = N·2·CLK_DIV + 1 ref clocks, with N:
  - TAP_RESET: 6
  - IR_SCAN: len+7
  - DR_SCAN: len+6
  - IDLE_CYCLES: len+1
- TCK is low when rsp_valid_o rises.
- rsp_valid_o high and rsp_ready_i low: hold indefinitely, cmd_ready_o=0. Next accept is possible one clock after the response handshake.
- cmd_valid_i while busy: ignored, not lost. The initiator must hold it.
- Reset values: cmd_ready_o=1, rsp_valid_o=0, rsp_data_o=0, jtag_tck_o=0, jtag_tms_o=1, jtag_tdi_o=0, busy_o=0.
- Reset mid-operation: immediate abort, outputs go to reset values, no response is issued.
- cmd_len_i=31: 32 bits shifted, and the last bit carries TMS=1. cmd_len_i=0: a single bit with TMS=1.

## Structure
- jtag_host_pkg holds:
  - cmd type encoding
  - FSM state enum
  - head TMS patterns and lengths (IR 4'b0011 LSB-first, DR 3'b001, RESET 6'b011111)
  - tail pattern 2'b01
- Sub-module jtag_host_tck_gen: divider counter producing jtag_tck_o plus single-clock fall_stb and rise_stb strobes, with an enable input.
- The top FSM holds the step counter, shift register and capture register.

## Test plan
- Reset then TAP_RESET, CLK_DIV=4: TMS sampled at TCK rises = 1,1,1,1,1,0; rsp_valid_o at 49 clocks; rsp_data_o=0.
- DR_SCAN, len=7, data=0xA5, TDO looped to TDI: TMS sequence 1,0,0,0×7,1,1,0; rsp_data_o=0x000000A5.
- IR_SCAN, len=4, data=0x05, against a TAP model with IR capture 0b00001: model IR=0x05; rsp_data_o=0x01.
- DR_SCAN, len=31, data=0xDEADBEEF, loopback: rsp_data_o=0xDEADBEEF; TMS=1 only on the 32nd shift bit.
- Back-pressure: rsp_ready_i low for 100 clocks: rsp_valid_o and rsp_data_o stable, cmd_ready_o=0, TCK static low; accept one clock after the handshake.
- pad_reset asserted mid-SHIFT of a 32-bit DR scan: next clock TCK=0, TMS=1, busy_o=0, no rsp_valid_o; a following TAP_RESET completes normally.

Source files
------------

// File: rtl/jtag_host_pkg.sv
// Shared types and TMS patterns for the fabric-side JTAG initiator.
// Patterns are stored LSB-first: bit 0 is driven on the first TCK of the phase.
package jtag_host_pkg;

    typedef enum logic [1:0] {
        CMD_TAP_RESET   = 2'd0,
        CMD_IR_SCAN     = 2'd1,
        CMD_DR_SCAN     = 2'd2,
        CMD_IDLE_CYCLES = 2'd3
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_SHIFT,
        ST_TAIL,
        ST_RESP
    } state_t;

    localparam logic [3:0] IR_HEAD_TMS = 4'b0011;
    localparam logic [4:0] IR_HEAD_LEN = 5'd4;
    localparam logic [2:0] DR_HEAD_TMS = 3'b001;
    localparam logic [4:0] DR_HEAD_LEN = 5'd3;
    localparam logic [5:0] RESET_TMS   = 6'b011111;
    localparam logic [4:0] RESET_LEN   = 5'd6;
    localparam logic [1:0] TAIL_TMS    = 2'b01;
    localparam logic [4:0] TAIL_LEN    = 5'd2;

    // Index of the last HEAD step; IDLE_CYCLES spends its whole run in HEAD.
    function automatic logic [4:0] head_last(input cmd_t c, input logic [4:0] len);
        case (c)
            CMD_TAP_RESET: return RESET_LEN - 5'd1;
            CMD_IR_SCAN:   return IR_HEAD_LEN - 5'd1;
            CMD_DR_SCAN:   return DR_HEAD_LEN - 5'd1;
            default:       return len;
        endcase
    endfunction

    function automatic logic head_tms(input cmd_t c, input logic [4:0] step);
        logic [5:0] pat;
        case (c)
            CMD_TAP_RESET: pat = RESET_TMS;
            CMD_IR_SCAN:   pat = {2'b00, IR_HEAD_TMS};
            CMD_DR_SCAN:   pat = {3'b000, DR_HEAD_TMS};
            default:       pat = '0;
        endcase
        pat = pat >> step;
        return pat[0];
    endfunction

endpackage

// File: rtl/jtag_host_tck_gen.sv
// TCK divider: low phase then high phase of CLK_DIV ref clocks each, held low when disabled.
// Strobes mark the ref clock edge on which TCK rises or falls.
module jtag_host_tck_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tck,
    output logic o_rise_stb,
    output logic o_fall_stb
);

    localparam int unsigned   CW      = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] RISE_AT = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] FALL_AT = CW'(2 * CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tck;

    assign o_rise_stb = i_en && (r_cnt == RISE_AT);
    assign o_fall_stb = i_en && (r_cnt == FALL_AT);
    assign o_tck      = r_tck;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (o_fall_stb) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
            if (o_rise_stb) begin
                r_tck <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtag_host_driver.sv
// Fabric JTAG initiator: turns TAP_RESET / IR / DR / idle commands into TCK/TMS/TDI
// and returns captured TDO bits through a valid/ready response port.
module jtag_host_driver
    import jtag_host_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        ref_clk_i,
    input  logic        pad_reset,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_type_i,
    input  logic [4:0]  cmd_len_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        jtag_tck_o,
    output logic        jtag_tms_o,
    output logic        jtag_tdi_o,
    input  logic        jtag_tdo_i,
    output logic        busy_o
);

    state_t      r_state, w_state_next;
    cmd_t        r_cmd;
    logic [4:0]  r_len;
    logic [4:0]  r_step, w_step_next;
    logic [31:0] r_shift;
    logic [31:0] r_capture;
    logic        r_tms, w_tms_next;
    logic        r_tdi, w_tdi_next;
    logic        r_rsp_valid;
    logic        w_tck_en, w_rise, w_fall, w_tck;
    logic        w_accept, w_last, w_load;

    function automatic logic tms_of(input state_t s, input logic [4:0] step,
                                    input cmd_t c, input logic [4:0] len);
        logic [1:0] tail;
        tail = TAIL_TMS >> step;
        case (s)
            ST_HEAD:  return head_tms(c, step);
            ST_SHIFT: return (step == len);
            ST_TAIL:  return tail[0];
            default:  return 1'b0;
        endcase
    endfunction

    assign w_tck_en = (r_state == ST_HEAD) || (r_state == ST_SHIFT) || (r_state == ST_TAIL);
    assign w_accept = cmd_valid_i && (r_state == ST_IDLE);
    assign w_load   = w_accept || w_fall;

    jtag_host_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .i_clk      (ref_clk_i),
        .i_rst      (pad_reset),
        .i_en       (w_tck_en),
        .o_tck      (w_tck),
        .o_rise_stb (w_rise),
        .o_fall_stb (w_fall)
    );

    always_comb begin
        case (r_state)
            ST_HEAD:  w_last = (r_step == head_last(r_cmd, r_len));
            ST_SHIFT: w_last = (r_step == r_len);
            ST_TAIL:  w_last = (r_step == TAIL_LEN - 5'd1);
            default:  w_last = 1'b0;
        endcase
    end

    always_ff @(posedge ref_clk_i or posedge pad_reset) begin
        if (pad_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Every falling TCK edge selects the next (state, step) and presents its TMS/TDI.
    always_comb begin
        w_state_next = r_state;
        w_step_next  = r_step;
        w_tms_next   = r_tms;
        w_tdi_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    w_state_next = ST_HEAD;
                    w_step_next  = '0;
                    w_tms_next   = tms_of(ST_HEAD, '0, cmd_t'(cmd_type_i), cmd_len_i);
                end
            end
            ST_HEAD, ST_SHIFT, ST_TAIL: begin
                if (w_fall) begin
                    if (w_last) begin
                        w_step_next = '0;
                        case (r_state)
                            ST_HEAD:  w_state_next = (r_cmd == CMD_IR_SCAN || r_cmd == CMD_DR_SCAN)
                                                     ? ST_SHIFT : ST_RESP;
                            ST_SHIFT: w_state_next = ST_TAIL;
                            default:  w_state_next = ST_RESP;
                        endcase
                    end else begin
                        w_step_next = r_step + 5'd1;
                    end
                    w_tms_next = tms_of(w_state_next, w_step_next, r_cmd, r_len);
                    if (w_state_next == ST_SHIFT) begin
                        w_tdi_next = r_shift[0];
                    end
                end
            end
            ST_RESP: begin
                if (r_rsp_valid && rsp_ready_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ref_clk_i or posedge pad_reset) begin
        if (pad_reset) begin
            r_cmd       <= CMD_TAP_RESET;
            r_len       <= '0;
            r_step      <= '0;
            r_shift     <= '0;
            r_capture   <= '0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_step <= w_step_next;
            if (w_accept) begin
                r_cmd     <= cmd_t'(cmd_type_i);
                r_len     <= cmd_len_i;
                r_shift   <= cmd_data_i;
                r_capture <= '0;
            end else if (w_fall && w_state_next == ST_SHIFT) begin
                r_shift <= r_shift >> 1;
            end
            if (w_load) begin
                r_tms <= w_tms_next;
                r_tdi <= w_tdi_next;
            end
            if (w_rise && r_state == ST_SHIFT) begin
                r_capture[r_step] <= jtag_tdo_i;
            end
            // Valid trails entry to RESP by one clock and drops on the handshake.
            if (r_rsp_valid && rsp_ready_i) begin
                r_rsp_valid <= 1'b0;
            end else if (r_state == ST_RESP) begin
                r_rsp_valid <= 1'b1;
            end
        end
    end

    assign cmd_ready_o = (r_state == ST_IDLE);
    assign busy_o      = (r_state != ST_IDLE);
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_capture;
    assign jtag_tck_o  = w_tck;
    assign jtag_tms_o  = r_tms;
    assign jtag_tdi_o  = r_tdi;

endmodule

// File: tb/tb_jtag_host_driver.sv
// Directed bench for jtag_host_driver: TMS sequences, latencies, loopback and TAP-model
// captures, response back-pressure and mid-scan reset.
module tb_jtag_host_driver;

    localparam int unsigned CLK_DIV = 4;

    logic        ref_clk_i = 1'b0;
    logic        pad_reset;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_type_i;
    logic [4:0]  cmd_len_i;
    logic [31:0] cmd_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        jtag_tck_o;
    logic        jtag_tms_o;
    logic        jtag_tdi_o;
    logic        jtag_tdo_i;
    logic        busy_o;

    int n_checks = 0;
    int n_fails  = 0;
    bit loop_mode = 1'b0;

    always #5 ref_clk_i = ~ref_clk_i;

    jtag_host_driver #(.CLK_DIV(CLK_DIV)) dut (
        .ref_clk_i   (ref_clk_i),
        .pad_reset   (pad_reset),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_type_i  (cmd_type_i),
        .cmd_len_i   (cmd_len_i),
        .cmd_data_i  (cmd_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .jtag_tck_o  (jtag_tck_o),
        .jtag_tms_o  (jtag_tms_o),
        .jtag_tdi_o  (jtag_tdi_o),
        .jtag_tdo_i  (jtag_tdo_i),
        .busy_o      (busy_o)
    );

    // Minimal 1149.1 TAP with a 5-bit IR whose capture value is 5'b00001.
    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PDR, T_EX2DR, T_UPDR,
        T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PIR, T_EX2IR, T_UPIR
    } tap_t;

    function automatic tap_t tap_next(input tap_t s, input logic tms);
        case (s)
            T_TLR:   return tms ? T_TLR   : T_RTI;
            T_RTI:   return tms ? T_SELDR : T_RTI;
            T_SELDR: return tms ? T_SELIR : T_CAPDR;
            T_CAPDR: return tms ? T_EX1DR : T_SHDR;
            T_SHDR:  return tms ? T_EX1DR : T_SHDR;
            T_EX1DR: return tms ? T_UPDR  : T_PDR;
            T_PDR:   return tms ? T_EX2DR : T_PDR;
            T_EX2DR: return tms ? T_UPDR  : T_SHDR;
            T_UPDR:  return tms ? T_SELDR : T_RTI;
            T_SELIR: return tms ? T_TLR   : T_CAPIR;
            T_CAPIR: return tms ? T_EX1IR : T_SHIR;
            T_SHIR:  return tms ? T_EX1IR : T_SHIR;
            T_EX1IR: return tms ? T_UPIR  : T_PIR;
            T_PIR:   return tms ? T_EX2IR : T_PIR;
            T_EX2IR: return tms ? T_UPIR  : T_SHIR;
            default: return tms ? T_SELDR : T_RTI;
        endcase
    endfunction

    tap_t       tap_st  = T_SHDR;
    logic [4:0] ir_sr   = 5'd0;
    logic [4:0] ir_reg  = 5'd0;
    logic       tap_tdo = 1'b0;
    logic       tms_q[$];

    always @(posedge jtag_tck_o) begin
        if (tap_st == T_CAPIR) ir_sr <= 5'b00001;
        else if (tap_st == T_SHIR) ir_sr <= {jtag_tdi_o, ir_sr[4:1]};
        if (tap_st == T_UPIR) ir_reg <= ir_sr;
        tap_st <= tap_next(tap_st, jtag_tms_o);
        tms_q.push_back(jtag_tms_o);
    end

    always @(negedge jtag_tck_o) begin
        tap_tdo <= (tap_st == T_SHIR) ? ir_sr[0] : 1'b0;
    end

    assign jtag_tdo_i = loop_mode ? jtag_tdi_o : tap_tdo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tms_since(input int mark, output logic [63:0] v, output int n);
        v = '0;
        n = tms_q.size() - mark;
        for (int i = 0; i < n && i < 64; i++) v[i] = tms_q[mark + i];
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid_o !== 1'b1 && lat < 2000) begin
            @(posedge ref_clk_i); #1;
            lat++;
        end
    endtask

    task automatic run_cmd(input logic [1:0] t, input logic [4:0] l, input logic [31:0] d,
                           output int lat);
        cmd_valid_i = 1'b1;
        cmd_type_i  = t;
        cmd_len_i   = l;
        cmd_data_i  = d;
        @(posedge ref_clk_i); #1;
        cmd_valid_i = 1'b0;
        cmd_data_i  = '0;
        wait_rsp(lat);
    endtask

    task automatic ack();
        rsp_ready_i = 1'b1;
        @(posedge ref_clk_i); #1;
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        int         lat;
        int         mark;
        int         n;
        logic [63:0] v;
        bit         seen;

        pad_reset   = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_type_i  = '0;
        cmd_len_i   = '0;
        cmd_data_i  = '0;
        rsp_ready_i = 1'b0;
        repeat (3) @(posedge ref_clk_i);
        #1;
        check("reset_ctrl", 64'({cmd_ready_o, rsp_valid_o, jtag_tck_o, jtag_tms_o, jtag_tdi_o, busy_o}),
              64'(6'b100100));
        check("reset_data", 64'(rsp_data_o), 64'd0);
        pad_reset = 1'b0;
        @(posedge ref_clk_i); #1;

        // TAP_RESET: 6 TCK, data ignored
        check("rst_ready", 64'(cmd_ready_o), 64'd1);
        mark = tms_q.size();
        run_cmd(2'd0, 5'd0, 32'hFFFF_FFFF, lat);
        check("rst_lat", 64'(lat), 64'd49);
        check("rst_data", 64'(rsp_data_o), 64'd0);
        check("rst_tck_low", 64'(jtag_tck_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd1);
        tms_since(mark, v, n);
        check("rst_tms_n", 64'(n), 64'd6);
        check("rst_tms", v, 64'h1F);
        check("rst_tap_rti", 64'(tap_st), 64'(T_RTI));
        ack();
        check("rst_ack", 64'({rsp_valid_o, busy_o}), 64'd0);

        // IR_SCAN len=4 against TAP model
        loop_mode = 1'b0;
        mark = tms_q.size();
        run_cmd(2'd1, 5'd4, 32'h0000_0005, lat);
        check("ir_lat", 64'(lat), 64'd89);
        check("ir_data", 64'(rsp_data_o), 64'h01);
        tms_since(mark, v, n);
        check("ir_tms_n", 64'(n), 64'd11);
        check("ir_tms", v, 64'h303);
        ack();
        check("ir_reg", 64'(ir_reg), 64'h05);
        check("ir_tap_rti", 64'(tap_st), 64'(T_RTI));

        // DR_SCAN len=7 loopback
        loop_mode = 1'b1;
        mark = tms_q.size();
        run_cmd(2'd2, 5'd7, 32'h0000_00A5, lat);
        check("dr8_lat", 64'(lat), 64'd105);
        check("dr8_data", 64'(rsp_data_o), 64'hA5);
        tms_since(mark, v, n);
        check("dr8_tms_n", 64'(n), 64'd13);
        check("dr8_tms", v, 64'hC01);
        ack();

        // IDLE_CYCLES len=2: TDI stays 0, so loopback must capture nothing
        mark = tms_q.size();
        run_cmd(2'd3, 5'd2, 32'hFFFF_FFFF, lat);
        check("idle_lat", 64'(lat), 64'd25);
        check("idle_data", 64'(rsp_data_o), 64'd0);
        tms_since(mark, v, n);
        check("idle_tms_n", 64'(n), 64'd3);
        check("idle_tms", v, 64'd0);
        ack();

        // DR_SCAN len=31 loopback, then response back-pressure with a pending command
        mark = tms_q.size();
        run_cmd(2'd2, 5'd31, 32'hDEAD_BEEF, lat);
        check("dr32_lat", 64'(lat), 64'd297);
        check("dr32_data", 64'(rsp_data_o), 64'hDEAD_BEEF);
        tms_since(mark, v, n);
        check("dr32_tms_n", 64'(n), 64'd37);
        check("dr32_tms", v, 64'h0000_000C_0000_0001);
        cmd_valid_i = 1'b1;
        cmd_type_i  = 2'd0;
        cmd_len_i   = 5'd0;
        for (int i = 0; i < 100; i++) begin
            @(posedge ref_clk_i); #1;
            check("bp_ctrl", 64'({rsp_valid_o, cmd_ready_o, jtag_tck_o, busy_o}), 64'(4'b1001));
            check("bp_data", 64'(rsp_data_o), 64'hDEAD_BEEF);
        end
        mark = tms_q.size();
        rsp_ready_i = 1'b1;
        @(posedge ref_clk_i); #1;
        rsp_ready_i = 1'b0;
        check("bp_hs", 64'({rsp_valid_o, cmd_ready_o, busy_o}), 64'(3'b010));
        @(posedge ref_clk_i); #1;
        cmd_valid_i = 1'b0;
        check("bp_accept", 64'({cmd_ready_o, busy_o}), 64'(2'b01));
        wait_rsp(lat);
        check("bp_rst_lat", 64'(lat), 64'd49);
        check("bp_rst_data", 64'(rsp_data_o), 64'd0);
        tms_since(mark, v, n);
        check("bp_rst_tms_n", 64'(n), 64'd6);
        check("bp_rst_tms", v, 64'h1F);
        ack();

        // pad_reset in the middle of a 32-bit DR shift
        cmd_valid_i = 1'b1;
        cmd_type_i  = 2'd2;
        cmd_len_i   = 5'd31;
        cmd_data_i  = 32'h1234_5678;
        @(posedge ref_clk_i); #1;
        cmd_valid_i = 1'b0;
        repeat (100) @(posedge ref_clk_i);
        #1;
        check("mid_busy", 64'(busy_o), 64'd1);
        pad_reset = 1'b1;
        @(posedge ref_clk_i); #1;
        check("mid_reset", 64'({jtag_tck_o, jtag_tms_o, jtag_tdi_o, busy_o, rsp_valid_o, cmd_ready_o}),
              64'(6'b010001));
        pad_reset = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(posedge ref_clk_i); #1;
            if (rsp_valid_o !== 1'b0 || jtag_tck_o !== 1'b0) seen = 1'b1;
        end
        check("mid_no_rsp", 64'(seen), 64'd0);
        mark = tms_q.size();
        run_cmd(2'd0, 5'd0, 32'd0, lat);
        check("post_lat", 64'(lat), 64'd49);
        check("post_data", 64'(rsp_data_o), 64'd0);
        tms_since(mark, v, n);
        check("post_tms_n", 64'(n), 64'd6);
        check("post_tms", v, 64'h1F);
        check("post_tap_rti", 64'(tap_st), 64'(T_RTI));
        ack();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
